zero_run_extractor: RTL and testbench

Upstream front-end for the zero-sequence max-run counter. It accepts a qualified serial bitstream and drives a per-bit zero enable that feeds the counter's enable input directly. It also measures each zero run itself, tolerating valid gaps, and reports run length and per-frame zero totals. Frames are fixed-length, and runs never cross a frame boundary.

---
 rtl/zero_run_pkg.sv | 7 +
 rtl/zero_run_extractor_if.sv | 26 ++
 rtl/zero_run_extractor_sat_counter.sv | 22 ++
 rtl/zero_run_extractor.sv | 79 +++++++
 tb/tb_zero_run_extractor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/zero_run_pkg.sv
// zero_run_pkg: shared state encoding and default sizing for the zero-run front-end
package zero_run_pkg;
    typedef enum logic {S_ONES, S_ZEROS} state_t;
    localparam int RUN_W_DEF     = 4;
    localparam int MAX_RUN_DEF   = 9;
    localparam int FRAME_LEN_DEF = 16;
endpackage

// File: rtl/zero_run_extractor_if.sv
// zero_run_if: serial bit input and run/frame report outputs of the zero-run extractor
interface zero_run_if
    import zero_run_pkg::*;
#(
    parameter int RUN_W     = RUN_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
);
    localparam int FRAME_W = $clog2(FRAME_LEN + 1);
    logic               i_VALID;
    logic               i_DATA;
    logic               i_CLEAR;
    logic               o_zero_en;
    logic [RUN_W-1:0]   o_run_len;
    logic               o_run_sat;
    logic               o_run_valid;
    logic [FRAME_W-1:0] o_frame_zeros;
    logic               o_frame_end;
    modport master (
        output i_VALID, i_DATA, i_CLEAR,
        input  o_zero_en, o_run_len, o_run_sat, o_run_valid, o_frame_zeros, o_frame_end
    );
    modport slave (
        input  i_VALID, i_DATA, i_CLEAR,
        output o_zero_en, o_run_len, o_run_sat, o_run_valid, o_frame_zeros, o_frame_end
    );
endinterface

// File: rtl/zero_run_extractor_sat_counter.sv
// sat_counter: saturating up-counter; clear with inc restarts at 1, sat flags a next value at MAX
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         i_clk,
    input  logic         i_NOT_RESET,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         sat
);
    always_comb begin
        nxt = clear ? W'(inc) : (inc && cnt != W'(MAX)) ? cnt + W'(1) : cnt;
        sat = nxt == W'(MAX);
    end

    always_ff @(posedge i_clk or negedge i_NOT_RESET)
        if (!i_NOT_RESET) cnt <= '0;
        else              cnt <= nxt;
endmodule

// File: rtl/zero_run_extractor.sv
// zero_run_extractor: per-bit zero enable plus run-length and per-frame zero-count reporting
module zero_run_extractor
    import zero_run_pkg::*;
#(
    parameter int RUN_W     = RUN_W_DEF,
    parameter int MAX_RUN   = MAX_RUN_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic      i_clk,
    input  logic      i_NOT_RESET,
    zero_run_if.slave bus
);
    localparam int FRAME_W = $clog2(FRAME_LEN + 1);

    state_t             state_q, state_d;
    logic               acc, zero, one, last, run_clr, run_event, run_sat;
    logic [RUN_W-1:0]   run_nxt, unused_run_cnt;
    logic [FRAME_W-1:0] bit_cnt, zero_cnt, unused_zero_nxt;
    logic               unused_zero_sat;

    always_comb begin
        acc       = bus.i_VALID & ~bus.i_CLEAR;
        zero      = acc & ~bus.i_DATA;
        one       = acc & bus.i_DATA;
        last      = acc & (bit_cnt == FRAME_W'(FRAME_LEN - 1));
        run_clr   = bus.i_CLEAR | (zero & (state_q == S_ONES));
        run_event = (one & (state_q == S_ZEROS)) | (zero & last);
        state_d   = (bus.i_CLEAR | last | one) ? S_ONES : zero ? S_ZEROS : state_q;
    end

    always_ff @(posedge i_clk or negedge i_NOT_RESET)
        if (!i_NOT_RESET) state_q <= S_ONES;
        else              state_q <= state_d;

    // A run counter left stale after a close is harmless: the next run start reloads it to 1
    sat_counter #(.W(RUN_W), .MAX(MAX_RUN)) u_run_cnt (
        .i_clk       (i_clk),
        .i_NOT_RESET (i_NOT_RESET),
        .clear       (run_clr),
        .inc         (zero),
        .cnt         (unused_run_cnt),
        .nxt         (run_nxt),
        .sat         (run_sat)
    );

    sat_counter #(.W(FRAME_W), .MAX(FRAME_LEN)) u_zero_cnt (
        .i_clk       (i_clk),
        .i_NOT_RESET (i_NOT_RESET),
        .clear       (bus.i_CLEAR | last),
        .inc         (zero & ~last),
        .cnt         (zero_cnt),
        .nxt         (unused_zero_nxt),
        .sat         (unused_zero_sat)
    );

    always_ff @(posedge i_clk or negedge i_NOT_RESET)
        if (!i_NOT_RESET)              bit_cnt <= '0;
        else if (bus.i_CLEAR || last)  bit_cnt <= '0;
        else if (acc)                  bit_cnt <= bit_cnt + FRAME_W'(1);

    always_ff @(posedge i_clk or negedge i_NOT_RESET)
        if (!i_NOT_RESET) begin
            bus.o_zero_en     <= 1'b0;
            bus.o_run_valid   <= 1'b0;
            bus.o_run_len     <= '0;
            bus.o_run_sat     <= 1'b0;
            bus.o_frame_end   <= 1'b0;
            bus.o_frame_zeros <= '0;
        end else begin
            bus.o_zero_en   <= zero;
            bus.o_run_valid <= run_event;
            bus.o_frame_end <= last;
            if (run_event) begin
                bus.o_run_len <= run_nxt;
                bus.o_run_sat <= run_sat;
            end
            if (last) bus.o_frame_zeros <= zero_cnt + FRAME_W'(zero);
        end
endmodule

// File: tb/tb_zero_run_extractor.sv
// tb_zero_run_extractor: table vectors, directed corner sequences and randomized model check
module tb_zero_run_extractor;
    import zero_run_pkg::*;
    localparam int MAX = MAX_RUN_DEF;
    localparam int FL  = FRAME_LEN_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    zero_run_if bus ();

    zero_run_extractor dut (
        .i_clk       (clk),
        .i_NOT_RESET (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Reference model: unbounded run length, clipped only when reported
    bit m_open;
    int m_len, m_bits, m_nz;
    bit e_zen, e_rv, e_sat, e_fe;
    int e_len, e_fz;

    typedef struct {
        bit v, d, c, zen, rv;
        int len;
        bit sat, fe;
        int fz;
    } vec_t;
    vec_t tbl[$];

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_open = 0; m_len = 0; m_bits = 0; m_nz = 0;
        e_zen = 0; e_rv = 0; e_sat = 0; e_fe = 0; e_len = 0; e_fz = 0;
    endfunction

    function automatic void model_step(bit v, bit d, bit c);
        e_zen = v && !c && !d;
        e_rv  = 0;
        e_fe  = 0;
        if (c) begin
            m_open = 0; m_len = 0; m_bits = 0; m_nz = 0;
        end else if (v) begin
            m_bits++;
            if (!d) begin
                m_open = 1; m_len++; m_nz++;
            end
            if ((d || m_bits == FL) && m_open) begin
                e_rv  = 1;
                e_len = (m_len > MAX) ? MAX : m_len;
                e_sat = (m_len >= MAX);
                m_open = 0; m_len = 0;
            end
            if (m_bits == FL) begin
                e_fe = 1; e_fz = m_nz; m_bits = 0; m_nz = 0;
            end
        end
    endfunction

    function automatic void add(bit v, bit d, bit c, bit zen, bit rv, int len, bit sat, bit fe, int fz);
        vec_t r;
        r = '{v, d, c, zen, rv, len, sat, fe, fz};
        tbl.push_back(r);
    endfunction

    task automatic cyc(input bit v, input bit d, input bit c);
        bus.i_VALID = v;
        bus.i_DATA  = d;
        bus.i_CLEAR = c;
        model_step(v, d, c);
        @(posedge clk);
        #1;
        chk("zero_en",     int'(bus.o_zero_en),     int'(e_zen));
        chk("run_valid",   int'(bus.o_run_valid),   int'(e_rv));
        chk("run_len",     int'(bus.o_run_len),     e_len);
        chk("run_sat",     int'(bus.o_run_sat),     int'(e_sat));
        chk("frame_end",   int'(bus.o_frame_end),   int'(e_fe));
        chk("frame_zeros", int'(bus.o_frame_zeros), e_fz);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_zero_en",   int'(bus.o_zero_en),     0);
        chk("rst_async_run_len",   int'(bus.o_run_len),     0);
        chk("rst_async_frame_zrs", int'(bus.o_frame_zeros), 0);
        for (int i = 0; i < 3; i++) begin
            bus.i_VALID = 1'($urandom);
            bus.i_DATA  = 1'($urandom);
            bus.i_CLEAR = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_zero_en",     int'(bus.o_zero_en),     0);
            chk("rst_run_valid",   int'(bus.o_run_valid),   0);
            chk("rst_run_len",     int'(bus.o_run_len),     0);
            chk("rst_run_sat",     int'(bus.o_run_sat),     0);
            chk("rst_frame_end",   int'(bus.o_frame_end),   0);
            chk("rst_frame_zeros", int'(bus.o_frame_zeros), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rv_cnt, fe_cnt;
        bus.i_VALID = 0;
        bus.i_DATA  = 0;
        bus.i_CLEAR = 0;
        do_reset();

        // 1,0,0,0,1 then an idle cycle
        add(1,1,0, 0,0,0,0,0,0);
        add(1,0,0, 1,0,0,0,0,0);
        add(1,0,0, 1,0,0,0,0,0);
        add(1,0,0, 1,0,0,0,0,0);
        add(1,1,0, 0,1,3,0,0,0);
        add(0,0,0, 0,0,3,0,0,0);
        // 0, gap, 0, gap, 0, 1: gaps neither close the run nor hold zero_en
        add(1,0,0, 1,0,3,0,0,0);
        add(0,0,0, 0,0,3,0,0,0);
        add(1,0,0, 1,0,3,0,0,0);
        add(0,1,0, 0,0,3,0,0,0);
        add(1,0,0, 1,0,3,0,0,0);
        add(1,1,0, 0,1,3,0,0,0);
        // finish the frame: 9 bits so far, 6 zeros
        for (int i = 0; i < 6; i++) add(1,1,0, 0,0,3,0,0,0);
        add(1,1,0, 0,0,3,0,1,6);

        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_zen", i), int'(bus.o_zero_en),     int'(tbl[i].zen));
            chk($sformatf("tbl%0d_rv",  i), int'(bus.o_run_valid),   int'(tbl[i].rv));
            chk($sformatf("tbl%0d_len", i), int'(bus.o_run_len),     tbl[i].len);
            chk($sformatf("tbl%0d_sat", i), int'(bus.o_run_sat),     int'(tbl[i].sat));
            chk($sformatf("tbl%0d_fe",  i), int'(bus.o_frame_end),   int'(tbl[i].fe));
            chk($sformatf("tbl%0d_fz",  i), int'(bus.o_frame_zeros), tbl[i].fz);
        end

        // twelve zeros then 1: saturated run, single report
        rv_cnt = 0;
        repeat (12) begin
            cyc(1, 0, 0);
            rv_cnt += int'(bus.o_run_valid);
        end
        cyc(1, 1, 0);
        chk("sat_early_pulses", rv_cnt, 0);
        chk("sat_run_valid", int'(bus.o_run_valid), 1);
        chk("sat_run_len",   int'(bus.o_run_len),   MAX);
        chk("sat_run_sat",   int'(bus.o_run_sat),   1);
        repeat (3) cyc(1, 1, 0);
        chk("sat_frame_end", int'(bus.o_frame_end),   1);
        chk("sat_frame_zrs", int'(bus.o_frame_zeros), 12);

        // 14 ones then 0,0: run flushed together with frame end
        repeat (14) cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("flush_run_valid", int'(bus.o_run_valid),   1);
        chk("flush_frame_end", int'(bus.o_frame_end),   1);
        chk("flush_run_len",   int'(bus.o_run_len),     2);
        chk("flush_frame_zrs", int'(bus.o_frame_zeros), 2);
        cyc(1, 0, 0);
        chk("newframe_rv", int'(bus.o_run_valid), 0);
        cyc(1, 1, 0);
        chk("newframe_len", int'(bus.o_run_len), 1);

        // four zeros then clear with a valid 0: run dropped, held values kept
        repeat (4) cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("clr_run_valid", int'(bus.o_run_valid),   0);
        chk("clr_zero_en",   int'(bus.o_zero_en),     0);
        chk("clr_run_len",   int'(bus.o_run_len),     1);
        chk("clr_frame_zrs", int'(bus.o_frame_zeros), 2);
        fe_cnt = 0;
        for (int i = 0; i < FL; i++) begin
            if (i == 5) cyc(0, 1, 0);
            cyc(1, 1, 0);
            if (i < FL - 1) fe_cnt += int'(bus.o_frame_end);
        end
        chk("clr_early_frame_end", fe_cnt, 0);
        chk("clr_frame_end",       int'(bus.o_frame_end),   1);
        chk("clr_frame_zrs",       int'(bus.o_frame_zeros), 0);

        // randomized traffic, zero-biased for long runs
        for (int i = 0; i < 2000; i++)
            cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 64) == 0);

        // async reset mid-stream, then more traffic
        #3;
        do_reset();
        for (int i = 0; i < 300; i++)
            cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 64) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
